// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and
// default sizing constants.
package countdown_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int WIDTH_DEF    = 10;
  localparam int PRESCALE_DEF = 4;

endpackage

// File: rtl/countdown_timer_if.sv
// Load/control/status bundle of the countdown timer. master drives the load
// and control inputs; slave is the timer itself.
interface countdown_timer_if #(
  parameter int WIDTH = 10
);
  logic             io_load_valid;
  logic             io_load_ready;
  logic [WIDTH-1:0] io_load_bits;
  logic             io_en;
  logic             io_auto;
  logic             io_abort;
  logic [WIDTH-1:0] io_count;
  logic             io_busy;
  logic             io_done;

  modport master (
    output io_load_valid, io_load_bits, io_en, io_auto, io_abort,
    input  io_load_ready, io_count, io_busy, io_done
  );

  modport slave (
    input  io_load_valid, io_load_bits, io_en, io_auto, io_abort,
    output io_load_ready, io_count, io_busy, io_done
  );
endinterface

// File: rtl/countdown_timer_prescaler.sv
// Prescaler for the countdown timer: counts enabled cycles 0..PRESCALE-1 and
// raises tick on the enabled cycle that completes a period. Only built when
// COUNTDOWN_PRESCALE_EN is defined.
module countdown_prescaler
  import countdown_timer_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] cnt_q;

  assign tick = enable && (cnt_q == PW'(PRESCALE - 1));

  // Clear wins over counting; the wrap on tick also covers the expiry clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       cnt_q <= '0;
    else if (clear)  cnt_q <= '0;
    else if (enable) cnt_q <= tick ? '0 : cnt_q + PW'(1);
  end
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with optional auto-reload and a registered
// one-cycle done pulse on expiry.
// Optional feature: define COUNTDOWN_PRESCALE_EN to decrement only every
// PRESCALE enabled RUN cycles; otherwise every enabled RUN cycle decrements.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int PRESCALE = PRESCALE_DEF
) (
  input logic               clock,
  input logic               reset,
  countdown_timer_if.slave  io
);
  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             done_q;
  logic             tick;

  assign io.io_load_ready = (state == IDLE);
  assign io.io_busy       = (state == RUN);
  assign io.io_count      = count_q;
  assign io.io_done       = done_q;

`ifdef COUNTDOWN_PRESCALE_EN
  logic pre_en;
  logic pre_clr;

  // Abort suppresses counting so the prescaler restarts cleanly on the next load.
  assign pre_en  = (state == RUN) && io.io_en && !io.io_abort;
  assign pre_clr = ((state == IDLE) && io.io_load_valid) ||
                   ((state == RUN) && io.io_abort);

  countdown_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (pre_en),
    .clear  (pre_clr),
    .tick   (tick)
  );
`else
  logic unused_prescale;

  // Without the prescaler every enabled cycle is a step; PRESCALE is inert.
  assign unused_prescale = (PRESCALE < 1);
  assign tick            = io.io_en;
`endif

  // Timer FSM: load in IDLE, count/expire/abort in RUN, done registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (io.io_load_valid) begin
            count_q  <= io.io_load_bits;
            reload_q <= io.io_load_bits;
            // A zero load expires immediately without entering RUN.
            if (io.io_load_bits != '0) state  <= RUN;
            else                       done_q <= 1'b1;
          end
        end
        RUN: begin
          if (io.io_abort) begin
            count_q <= '0;
            state   <= IDLE;
          end else if (tick) begin
            if (count_q > WIDTH'(1)) begin
              count_q <= count_q - WIDTH'(1);
            end else begin
              done_q <= 1'b1;
              if (io.io_auto) begin
                count_q <= reload_q;
              end else begin
                count_q <= '0;
                state   <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
